// File: rtl/ex_alu_stage.sv
// ex_alu_stage: execute-stage ALU with single-cycle logic/arith/compare ops
// and an iterative 1-bit-per-cycle shifter for SLL/SRL/SRA.
// Results are registered at the EX/MEM boundary. Ready/valid handshakes
// connect the stage upstream (hazard unit) and downstream (MEM stage).
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   flush              synchronous kill of in-flight/accepted op
//   in_valid/in_ready  upstream handshake (in_ready is combinational)
//   Operation          ALU op code
//   SrcA, SrcB         operands (shift amount = SrcB[4:0])
//   rd_in              destination tag carried to rd_out
//   out_valid/out_ready downstream handshake
//   ALUResult, BrTaken, rd_out  registered results
module ex_alu_stage #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned OPCODE_LENGTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [OPCODE_LENGTH-1:0] Operation,
   input  logic [DATA_WIDTH-1:0]    SrcA,
   input  logic [DATA_WIDTH-1:0]    SrcB,
   input  logic [4:0]               rd_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    ALUResult,
   output logic                     BrTaken,
   output logic [4:0]               rd_out
);

   localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);

   localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
   localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
   localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0010);
   localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0100);
   localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0101);
   localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
   localparam logic [OPCODE_LENGTH-1:0] OP_NE  = OPCODE_LENGTH'(4'b1001);
   localparam logic [OPCODE_LENGTH-1:0] OP_LT  = OPCODE_LENGTH'(4'b1010);
   localparam logic [OPCODE_LENGTH-1:0] OP_GE  = OPCODE_LENGTH'(4'b1011);
   localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b1100);
   localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b1101);
   localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b1110);

   // Shift direction/fill, taken from the low two op-code bits.
   localparam logic [1:0] KIND_SLL = 2'b00;
   localparam logic [1:0] KIND_SRL = 2'b01;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t                 state_q;
   logic [DATA_WIDTH-1:0]  acc_q;
   logic [SHAMT_W-1:0]     cnt_q;
   logic [4:0]             tag_q;
   logic [1:0]             kind_q;
   logic                   out_valid_q;
   logic [DATA_WIDTH-1:0]  result_q;
   logic                   br_q;
   logic [4:0]             rd_q;

   logic [DATA_WIDTH-1:0]  res_c;
   logic                   cond_c;
   logic                   is_shift_c;
   logic [SHAMT_W-1:0]     shamt_c;
   logic [DATA_WIDTH-1:0]  acc_sh_c;
   logic                   accept_c;

   assign shamt_c   = SrcB[SHAMT_W-1:0];
   assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
   assign accept_c  = in_valid && in_ready;

   assign out_valid = out_valid_q;
   assign ALUResult = result_q;
   assign BrTaken   = br_q;
   assign rd_out    = rd_q;

   // Single-cycle result; shift ops yield SrcA, which is the answer for a zero amount.
   always_comb begin
      res_c      = '0;
      cond_c     = 1'b0;
      is_shift_c = 1'b0;
      case (Operation)
         OP_AND: res_c = SrcA & SrcB;
         OP_OR:  res_c = SrcA | SrcB;
         OP_XOR: res_c = SrcA ^ SrcB;
         OP_ADD: res_c = SrcA + SrcB;
         OP_SUB: res_c = SrcA - SrcB;
         OP_EQ: begin
            cond_c = (SrcA == SrcB);
            res_c  = DATA_WIDTH'(cond_c);
         end
         OP_NE: begin
            cond_c = (SrcA != SrcB);
            res_c  = DATA_WIDTH'(cond_c);
         end
         OP_LT: begin
            cond_c = ($signed(SrcA) < $signed(SrcB));
            res_c  = DATA_WIDTH'(cond_c);
         end
         OP_GE: begin
            cond_c = ($signed(SrcA) >= $signed(SrcB));
            res_c  = DATA_WIDTH'(cond_c);
         end
         OP_SLL, OP_SRL, OP_SRA: begin
            is_shift_c = 1'b1;
            res_c      = SrcA;
         end
         default: ;
      endcase
   end

   // One-bit step of the iterative shifter.
   always_comb begin
      case (kind_q)
         KIND_SLL: acc_sh_c = acc_q << 1;
         KIND_SRL: acc_sh_c = acc_q >> 1;
         default:  acc_sh_c = {acc_q[DATA_WIDTH-1], acc_q[DATA_WIDTH-1:1]};
      endcase
   end

   // Control FSM plus output/shift registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         tag_q       <= '0;
         kind_q      <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         br_q        <= 1'b0;
         rd_q        <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
      end else begin
         if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (accept_c) begin
                  if (is_shift_c && (shamt_c != '0)) begin
                     acc_q   <= SrcA;
                     cnt_q   <= shamt_c;
                     tag_q   <= rd_in;
                     kind_q  <= Operation[1:0];
                     state_q <= S_SHIFT;
                  end else begin
                     result_q    <= res_c;
                     br_q        <= cond_c;
                     rd_q        <= rd_in;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            S_SHIFT: begin
               acc_q <= acc_sh_c;
               cnt_q <= cnt_q - SHAMT_W'(1);
               // Output slot is guaranteed empty here: accept required it drained.
               if (cnt_q == SHAMT_W'(1)) begin
                  result_q    <= acc_sh_c;
                  br_q        <= 1'b0;
                  rd_q        <= tag_q;
                  out_valid_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
